// File: rtl/dm_port_sequencer_if.sv
// Requester port bundle for dm_port_sequencer; one instance per requester.
// The requester drives the master side, the sequencer the slave side.
interface dm_port_sequencer_if #(
  parameter int ADDR_W = 9
) ();
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              unsign;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              done;
  logic [31:0]       rdata;

  modport master (
    output req, we, size, unsign, addr, wdata,
    input  gnt, done, rdata
  );

  modport slave (
    input  req, we, size, unsign, addr, wdata,
    output gnt, done, rdata
  );
endinterface

// File: rtl/dm_port_sequencer.sv
// Two-requester round-robin arbiter that splits byte/half/word accesses into byte beats
// on a byte-wide RAM. Optional misalignment trap enabled by macro DM_ALIGN_CHECK_EN.
module dm_port_sequencer #(
  parameter int ADDR_W    = 9,
  parameter int RAM_BYTES = 512
) (
  input  logic               clk,
  input  logic               rst,
  dm_port_sequencer_if.slave r0,
  dm_port_sequencer_if.slave r1,
  output logic               err,
  output logic               busy,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] RAM_LIM = (ADDR_W + 1)'(RAM_BYTES);

  state_e            state_q, state_d;
  logic              rr_last_q, sel_q, we_q, unsign_q, err_q;
  logic [1:0]        size_q, beat_q, last_beat_s;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata0_q, rdata1_q, rdata_asm_s;
  logic [23:0]       buf_q;
  logic              grant_s, win_s, mis_s;
  logic              win_we_s, win_unsign_s;
  logic [1:0]        win_size_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [31:0]       win_wdata_s;

  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a, input logic [1:0] i);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {{(ADDR_W - 1){1'b0}}, i};
    if (s >= RAM_LIM) begin
      s = s - RAM_LIM;
    end else begin
      s = s;
    end
    return s[ADDR_W-1:0];
  endfunction

  // Final byte arrives straight from the RAM in CAPT; earlier bytes come from buf.
  function automatic logic [31:0] extend(input logic [23:0] b, input logic [7:0] last,
                                         input logic [1:0] size, input logic uns);
    logic [31:0] v;
    case (size)
      2'b00:   v = {{24{~uns & last[7]}}, last};
      2'b01:   v = {{16{~uns & last[7]}}, last, b[7:0]};
      default: v = {last, b[23:0]};
    endcase
    return v;
  endfunction

  assign win_we_s     = win_s ? r1.we     : r0.we;
  assign win_size_s   = win_s ? r1.size   : r0.size;
  assign win_unsign_s = win_s ? r1.unsign : r0.unsign;
  assign win_addr_s   = win_s ? r1.addr   : r0.addr;
  assign win_wdata_s  = win_s ? r1.wdata  : r0.wdata;

`ifdef DM_ALIGN_CHECK_EN
  assign mis_s = grant_s & (((win_size_s == 2'b01) & win_addr_s[0]) |
                            (win_size_s[1] & (win_addr_s[1:0] != 2'b00)));
`else
  assign mis_s = 1'b0;
`endif

  assign last_beat_s = (size_q == 2'b00) ? 2'd0 : ((size_q == 2'b01) ? 2'd1 : 2'd3);
  assign rdata_asm_s = extend(buf_q, mem_rdata, size_q, unsign_q);

  // Arbitration: only in IDLE; on contention the requester not served last wins
  always_comb begin
    grant_s = 1'b0;
    win_s   = 1'b0;
    if (state_q == IDLE) begin
      if (r0.req && r1.req) begin
        grant_s = 1'b1;
        win_s   = ~rr_last_q;
      end else if (r0.req) begin
        grant_s = 1'b1;
        win_s   = 1'b0;
      end else if (r1.req) begin
        grant_s = 1'b1;
        win_s   = 1'b1;
      end else begin
        grant_s = 1'b0;
        win_s   = 1'b0;
      end
    end else begin
      grant_s = 1'b0;
      win_s   = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d = mis_s ? DONE : BEAT;
        end else begin
          state_d = IDLE;
        end
      end
      BEAT: begin
        if (beat_q == last_beat_s) begin
          state_d = we_q ? DONE : CAPT;
        end else begin
          state_d = BEAT;
        end
      end
      CAPT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write byte lane for the current beat
  always_comb begin
    mem_wdata = 8'h00;
    if (state_q == BEAT) begin
      case (beat_q)
        2'd0:    mem_wdata = wdata_q[7:0];
        2'd1:    mem_wdata = wdata_q[15:8];
        2'd2:    mem_wdata = wdata_q[23:16];
        default: mem_wdata = wdata_q[31:24];
      endcase
    end else begin
      mem_wdata = 8'h00;
    end
  end

  assign mem_en   = (state_q == BEAT);
  assign mem_we   = mem_en & we_q;
  assign mem_addr = mem_en ? wrap_add(addr_q, beat_q) : {ADDR_W{1'b0}};
  assign busy     = (state_q != IDLE);
  assign err      = (state_q == DONE) & err_q;

  assign r0.gnt   = grant_s & ~win_s;
  assign r1.gnt   = grant_s & win_s;
  assign r0.done  = (state_q == DONE) & ~sel_q;
  assign r1.done  = (state_q == DONE) & sel_q;
  assign r0.rdata = rdata0_q;
  assign r1.rdata = rdata1_q;

  // State, access latch, byte capture and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      unsign_q  <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= 2'b00;
      beat_q    <= 2'd0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= 32'h0000_0000;
      buf_q     <= 24'h00_0000;
      rdata0_q  <= 32'h0000_0000;
      rdata1_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_s) begin
            rr_last_q <= win_s;
            sel_q     <= win_s;
            we_q      <= win_we_s;
            size_q    <= win_size_s;
            unsign_q  <= win_unsign_s;
            addr_q    <= win_addr_s;
            wdata_q   <= win_wdata_s;
            err_q     <= mis_s;
            beat_q    <= 2'd0;
          end
        end
        BEAT: begin
          beat_q <= beat_q + 2'd1;
          // RAM answers one cycle late, so this cycle carries the previous beat's byte
          if (!we_q) begin
            case (beat_q)
              2'd1:    buf_q[7:0]   <= mem_rdata;
              2'd2:    buf_q[15:8]  <= mem_rdata;
              2'd3:    buf_q[23:16] <= mem_rdata;
              default: buf_q        <= buf_q;
            endcase
          end
        end
        CAPT: begin
          if (sel_q) begin
            rdata1_q <= rdata_asm_s;
          end else begin
            rdata0_q <= rdata_asm_s;
          end
        end
        DONE: begin
          err_q  <= 1'b0;
          beat_q <= 2'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_sequencer.sv
// Self-checking bench for dm_port_sequencer: directed cases plus random accesses
// compared against a transaction-level byte-memory model.
module tb_dm_port_sequencer;

  logic       clk;
  logic       rst;
  logic       preload;
  logic       err, busy, mem_en, mem_we;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  dm_port_sequencer_if #(.ADDR_W(9)) r0_if ();
  dm_port_sequencer_if #(.ADDR_W(9)) r1_if ();

  dm_port_sequencer #(.ADDR_W(9), .RAM_BYTES(512)) dut (
    .clk       (clk),
    .rst       (rst),
    .r0        (r0_if),
    .r1        (r1_if),
    .err       (err),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int          checks;
  int          failures;
  logic [7:0]  ram     [0:511];
  logic [7:0]  ref_mem [0:511];
  logic [31:0] last_rd [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Byte-wide RAM with registered read
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) ram[i] <= pat(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic [31:0] exp_load(input logic [8:0] a, input logic [1:0] sz, input bit uns);
    int n;
    logic [31:0] v;
    n = nbytes(sz);
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[(int'(a) + k) % 512]) << (8 * k));
    if (n < 4 && !uns && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic drive(input int p, input bit rq, input bit we, input logic [1:0] sz,
                       input bit uns, input logic [8:0] a, input logic [31:0] wd);
    if (p == 0) begin
      r0_if.req = rq; r0_if.we = we; r0_if.size = sz; r0_if.unsign = uns;
      r0_if.addr = a; r0_if.wdata = wd;
    end else begin
      r1_if.req = rq; r1_if.we = we; r1_if.size = sz; r1_if.unsign = uns;
      r1_if.addr = a; r1_if.wdata = wd;
    end
  endtask

  function automatic logic get_gnt(input int p);
    return (p == 0) ? r0_if.gnt : r1_if.gnt;
  endfunction

  function automatic logic get_done(input int p);
    return (p == 0) ? r0_if.done : r1_if.done;
  endfunction

  function automatic logic [31:0] get_rdata(input int p);
    return (p == 0) ? r0_if.rdata : r1_if.rdata;
  endfunction

  // One complete access on port p with cycle-by-cycle checks from the grant cycle T
  task automatic access(input int p, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [8:0] a, input logic [31:0] wd);
    int n;
    bit mis;
    bit got;
    logic [31:0] exp;
    n   = nbytes(sz);
    mis = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`endif
    exp = (we || mis) ? last_rd[p] : exp_load(a, sz, uns);
    @(posedge clk); #1;
    drive(p, 1'b1, we, sz, uns, a, wd);
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      got = get_gnt(p);
    end
    chk("gnt", 32'(got), 32'd1);
    if (!got) begin
      drive(p, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
      return;
    end
    chk("gnt_other", 32'(get_gnt(1 - p)), 32'd0);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'd1);
      if (mis) begin
        chk("mis_done", 32'(get_done(p)), 32'd1);
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_mem_en", 32'(mem_en), 32'd0);
        chk("mis_rdata", get_rdata(p), exp);
        break;
      end else if (k <= n) begin
        chk("beat_en", 32'(mem_en), 32'd1);
        chk("beat_we", 32'(mem_we), 32'(we));
        chk("beat_addr", 32'(mem_addr), 32'((int'(a) + k - 1) % 512));
        if (we) chk("beat_wdata", 32'(mem_wdata), 32'(wd[8 * (k - 1) +: 8]));
        chk("beat_nodone", 32'(get_done(p)), 32'd0);
      end else if (we) begin
        chk("st_done", 32'(get_done(p)), 32'd1);
        chk("st_err", 32'(err), 32'd0);
        break;
      end else if (k == n + 1) begin
        chk("capt_en", 32'(mem_en), 32'd0);
        chk("capt_nodone", 32'(get_done(p)), 32'd0);
      end else begin
        chk("ld_done", 32'(get_done(p)), 32'd1);
        chk("ld_rdata", get_rdata(p), exp);
      end
    end
    chk("other_done", 32'(get_done(1 - p)), 32'd0);
    chk("other_rdata", get_rdata(1 - p), last_rd[1 - p]);
    if (!we && !mis) last_rd[p] = exp;
    if (we && !mis) begin
      for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % 512] = wd[8 * k +: 8];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
  endtask

  initial begin
    int gp [4];
    int gt [4];
    int dt [4];
    int ng;
    int nd;
    bit got;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 512; i++) ref_mem[i] = pat(i);
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
    rst = 1'b1;
    preload = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    preload = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;

    @(negedge clk);
    chk("rst_gnt0", 32'(r0_if.gnt), 32'd0);
    chk("rst_gnt1", 32'(r1_if.gnt), 32'd0);
    chk("rst_done0", 32'(r0_if.done), 32'd0);
    chk("rst_done1", 32'(r1_if.done), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rdata0", r0_if.rdata, 32'd0);
    chk("rst_rdata1", r1_if.rdata, 32'd0);

    // Directed word store and reloads with fixed expected values
    access(0, 1'b1, 2'b10, 1'b0, 9'h010, 32'hA1B2_C3D4);
    access(1, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0);
    chk("lw_0x010", r1_if.rdata, 32'hA1B2_C3D4);
    access(1, 1'b0, 2'b01, 1'b0, 9'h012, 32'h0);
    chk("lh_0x012", r1_if.rdata, 32'hFFFF_A1B2);
    access(1, 1'b0, 2'b01, 1'b1, 9'h012, 32'h0);
    chk("lhu_0x012", r1_if.rdata, 32'h0000_A1B2);
    access(1, 1'b0, 2'b00, 1'b0, 9'h010, 32'h0);
    chk("lb_0x010", r1_if.rdata, 32'hFFFF_FFD4);
    access(1, 1'b0, 2'b00, 1'b1, 9'h010, 32'h0);
    chk("lbu_0x010", r1_if.rdata, 32'h0000_00D4);

`ifdef DM_ALIGN_CHECK_EN
    access(1, 1'b0, 2'b10, 1'b0, 9'h013, 32'h0);
    chk("align_rdata", r1_if.rdata, 32'h0000_00D4);
`else
    access(0, 1'b1, 2'b10, 1'b0, 9'h1FE, 32'h1122_3344);
    access(0, 1'b0, 2'b10, 1'b0, 9'h1FE, 32'h0);
    chk("wrap_lw", r0_if.rdata, 32'h1122_3344);
`endif

    // Arbitration from reset with both requests held
    do_reset();
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0);
    drive(1, 1'b1, 1'b0, 2'b00, 1'b1, 9'h012, 32'h0);
    ng = 0;
    nd = 0;
    for (int c = 0; c < 80 && nd < 4; c++) begin
      @(negedge clk);
      if ((r0_if.gnt || r1_if.gnt) && ng < 4) begin
        gp[ng] = r1_if.gnt ? 1 : 0;
        gt[ng] = c;
        ng++;
        if (ng == 4) begin
          @(posedge clk); #1;
          drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
          drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
        end
      end
      if ((r0_if.done || r1_if.done) && nd < 4) begin
        dt[nd] = c;
        nd++;
      end
    end
    chk("arb_grants", 32'(ng), 32'd4);
    chk("arb_dones", 32'(nd), 32'd4);
    if (ng == 4 && nd == 4) begin
      for (int i = 0; i < 4; i++) chk("arb_order", 32'(gp[i]), 32'(i % 2));
      for (int i = 0; i < 3; i++) chk("arb_regrant", 32'(gt[i + 1]), 32'(dt[i] + 1));
      chk("arb_gnt_to_done0", 32'(dt[0] - gt[0]), 32'd6);
      chk("arb_gnt_to_done1", 32'(dt[1] - gt[1]), 32'd3);
    end
    last_rd[0] = exp_load(9'h010, 2'b10, 1'b0);
    last_rd[1] = exp_load(9'h012, 2'b00, 1'b1);
    chk("arb_rdata0", r0_if.rdata, last_rd[0]);
    chk("arb_rdata1", r1_if.rdata, last_rd[1]);

    // Reset during beat 2 of a word store
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 9'h100, 32'hCAFE_F00D);
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      got = r0_if.gnt;
    end
    chk("rstmid_gnt", 32'(got), 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
    repeat (3) @(negedge clk);
    chk("rstmid_addr", 32'(mem_addr), 32'h102);
    rst = 1'b1;
    #1;
    chk("rstmid_mem_en", 32'(mem_en), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(r0_if.done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    ref_mem[9'h100] = 8'h0D;
    ref_mem[9'h101] = 8'hF0;
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 9'h100, 32'h0);
    drive(1, 1'b1, 1'b0, 2'b00, 1'b1, 9'h000, 32'h0);
    @(negedge clk);
    chk("rstmid_arb0", 32'(r0_if.gnt), 32'd1);
    chk("rstmid_arb1", 32'(r1_if.gnt), 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
    got = 1'b0;
    for (int w = 0; w < 12 && !got; w++) begin
      @(negedge clk);
      got = r0_if.done;
    end
    chk("rstmid_done_seen", 32'(got), 32'd1);
    last_rd[0] = exp_load(9'h100, 2'b10, 1'b0);
    chk("rstmid_rdata", r0_if.rdata, last_rd[0]);

    // Random accesses against the memory model
    for (int i = 0; i < 80; i++) begin
      access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_port_sequencer.md
Name: dm_port_sequencer

Overview:
- Two-requester arbiter and access sequencer in front of a single-port, byte-wide data RAM of RAM_BYTES bytes.
- Requester 0 is the CPU load/store path. Requester 1 is the debug/loader port.
- Byte, halfword and word accesses are split into 1, 2 or 4 little-endian byte beats.
- Read data is reassembled and sign- or zero-extended to 32 bits.

Parameters:
- ADDR_W, 9, byte address width
- RAM_BYTES, 512, RAM size in bytes; addresses wrap modulo RAM_BYTES

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rN_req  in  1  request for requester N (N = 0, 1); the rN_* group below repeats for each N
- rN_we  in  1  1 = store, 0 = load
- rN_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word)
- rN_unsign  in  1  zero-extend loads (lbu/lhu)
- rN_addr  in  ADDR_W  byte address
- rN_wdata  in  32  store data
- rN_gnt  out  1  grant; combinational, same cycle as the request is accepted
- rN_done  out  1  one-cycle completion pulse
- rN_rdata  out  32  load result; valid with rN_done and held until that port's next load done
- err  out  1  misalignment error pulse (Optional Feature)
- busy  out  1  high whenever the state is not IDLE
- mem_en  out  1  RAM byte access strobe
- mem_we  out  1  RAM byte write
- mem_addr  out  ADDR_W  RAM byte address
- mem_wdata  out  8  RAM write byte
- mem_rdata  in  8  RAM read byte; registered, valid the cycle after mem_en with mem_we = 0

Behaviour:
- Reset (async): state = IDLE; rr_last = 1 (requester 0 has priority first).
- Reset values: all gnt, done, mem_en, mem_we, err and busy = 0; mem_addr = 0; mem_wdata = 0; rdata = 0; beat counter = 0.
- Reset mid-access abandons the access. No done is issued. Bytes already written stay written.
- States: IDLE, BEAT, CAPT, DONE.
- IDLE, arbitration:
  - Only requester 0 requesting: grant 0. Only requester 1 requesting: grant 1.
  - Both requesting: grant the requester that was not served last.
  - Winner sees gnt = 1 this cycle. we, size, unsign, addr and wdata are latched at the clock edge. rr_last is updated. Next state = BEAT.
- Beat count: n = 1 / 2 / 4 for byte / half / word.
- BEAT, beat i = 0..n-1, one cycle each:
  - mem_en = 1, mem_we = latched we.
  - mem_addr = (addr + i) mod RAM_BYTES.
  - mem_wdata = wdata[8i+7:8i].
  - After beat n-1: stores go to DONE; loads go to CAPT.
- Load capture: the byte returned for beat i is registered in the cycle after beat i. The final byte is registered in CAPT. mem_en = 0 in CAPT.
- Load extension:
  - Half: upper 16 bits = byte1[7] if signed, else 0.
  - Byte: upper 24 bits = byte0[7] if signed, else 0.
  - Word: no extension.
- DONE: the served port's done = 1 for one cycle; for loads its rdata updates on entering DONE. Next state = IDLE. No arbitration happens in DONE.
- Latency from the grant cycle T:
  - Store done at T+n+1.
  - Load done at T+n+2.
  - A request held continuously is granted again at the earliest in the cycle after done.
- req deasserted after gnt has no effect; the latched access completes. Requester inputs are ignored outside IDLE.
- The non-served port's gnt, done and rdata are unaffected.
- Address wrap-around modulo RAM_BYTES is applied per beat.

Optional Feature:
- Macro: DM_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, a granted request that is misaligned (half with addr[0] = 1, or word with addr[1:0] != 0) performs no beats.
  - Next state = DONE. err = 1 together with done. rdata is unchanged.
- Undefined: err is tied 0, and misaligned accesses proceed byte-wise with wrap-around.

Test Plan:
- Word store: r0 store, addr 0x010, wdata 0xA1B2C3D4, gnt at T -> mem writes D4, C3, B2, A1 to 0x010..0x013 on T+1..T+4; r0_done at T+5; busy high T+1..T+5.
- Loads by r1 after that store:
  - lw 0x010 -> 0xA1B2C3D4, done at T+6.
  - lh 0x012 -> 0xFFFFA1B2; lhu 0x012 -> 0x0000A1B2.
  - lb 0x010 -> 0xFFFFFFD4; lbu 0x010 -> 0x000000D4.
- Arbitration: r0 and r1 request in the same cycle from reset -> r0 granted first, r1 granted in the cycle after r0_done. Both held continuously -> grants alternate 0, 1, 0, 1.
- Wrap: with DM_ALIGN_CHECK_EN undefined, word store at 0x1FE, data 0x11223344 -> writes 44 @0x1FE, 33 @0x1FF, 22 @0x000, 11 @0x001; lw 0x1FE returns 0x11223344.
- Reset: rst pulsed during beat 2 of a word store -> asynchronous return to IDLE, mem_en = 0 immediately, no done; the next request from r0 wins arbitration.
- Align check: with DM_ALIGN_CHECK_EN defined, lw 0x013 -> no mem_en, err = 1 and done = 1 at T+1, rdata unchanged.
